alu_issue_stage: RTL and testbench

- Decode/issue stage that drives the 64-bit ALU from the upstream side: takes RV64I OP, OP-IMM, OP-32, OP-IMM-32, LUI and AUIPC instructions with register operands, and produces alu_control, operand_a, operand_b and rd.
- Sits between register-file read and the execute stage; the ALU consumes its outputs combinationally.
- Registered output with a valid/ready handshake and a one-entry skid buffer, so it accepts one instruction per cycle at full throughput.

---
 rtl/alu_issue_stage.sv | 119 +++++++++++
 tb/tb_alu_issue_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV64I ALU decode/issue stage with a registered output and a one-entry skid buffer
module alu_issue_stage #(
    parameter int WIDTH        = 64,
    parameter bit PASS_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_rs1_data,
    input  logic [WIDTH-1:0] in_rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_alu_control,
    output logic [WIDTH-1:0] out_operand_a,
    output logic [WIDTH-1:0] out_operand_b,
    output logic [4:0]       out_rd,
    output logic             out_word,
    output logic             out_illegal
);
    localparam int EW = 2 * WIDTH + 12;

    logic [6:0]       opc, f7;
    logic [5:0]       f6;
    logic [2:0]       f3;
    logic             sh, op_ok, opimm_ok, op32_ok, opimm32_ok;
    logic [WIDTH-1:0] imm_i, imm_u, shamt;
    logic [4:0]       f3_ctl, d_ctl;
    logic [WIDTH-1:0] d_a, d_b;
    logic             d_word, d_ok;
    logic [EW-1:0]    d_ent, out_q, skid_q;
    logic             skid_valid, enq;

    assign opc   = in_instr[6:0];
    assign f3    = in_instr[14:12];
    assign f7    = in_instr[31:25];
    assign f6    = in_instr[31:26];
    assign imm_i = {{(WIDTH-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_u = {{(WIDTH-32){in_instr[31]}}, in_instr[31:12], 12'b0};
    assign shamt = {{(WIDTH-6){1'b0}}, in_instr[25:20]};
    assign sh    = (f3 == 3'd1) || (f3 == 3'd5);

    // funct7 0100000 is only meaningful for ADD/SUB and SRL/SRA
    assign op_ok      = (f7 == 7'd0) || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5));
    assign opimm_ok   = !sh || (f6 == 6'd0) || (f6 == 6'b010000 && f3 == 3'd5);
    assign op32_ok    = op_ok && (f3 == 3'd0 || sh);
    assign opimm32_ok = (f3 == 3'd0) || (sh && ((f7 == 7'd0) || (f7 == 7'b0100000 && f3 == 3'd5)));

    // funct3 to ALU op; instr[30] picks SUB/SRA on the alternate encodings
    always_comb begin
        case (f3)
            3'd0:    f3_ctl = in_instr[30] ? 5'd1 : 5'd0;
            3'd1:    f3_ctl = 5'd5;
            3'd2:    f3_ctl = 5'd8;
            3'd3:    f3_ctl = 5'd9;
            3'd4:    f3_ctl = 5'd4;
            3'd5:    f3_ctl = in_instr[30] ? 5'd7 : 5'd6;
            3'd6:    f3_ctl = 5'd3;
            default: f3_ctl = 5'd2;
        endcase
    end

    // opcode decode; illegal instructions collapse to an all-zero ADD entry
    always_comb begin
        d_ctl  = 5'd0;
        d_a    = '0;
        d_b    = '0;
        d_word = 1'b0;
        d_ok   = 1'b0;
        case (opc)
            7'b0110011: begin d_ok = op_ok;      d_ctl = f3_ctl; d_a = in_rs1_data; d_b = in_rs2_data; end
            7'b0010011: begin d_ok = opimm_ok;   d_ctl = (f3 == 3'd0) ? 5'd0 : f3_ctl; d_a = in_rs1_data; d_b = sh ? shamt : imm_i; end
            7'b0111011: begin d_ok = op32_ok;    d_ctl = f3_ctl; d_a = in_rs1_data; d_b = in_rs2_data; d_word = 1'b1; end
            7'b0011011: begin d_ok = opimm32_ok; d_ctl = (f3 == 3'd0) ? 5'd0 : f3_ctl; d_a = in_rs1_data; d_b = sh ? shamt : imm_i; d_word = 1'b1; end
            7'b0110111: begin d_ok = 1'b1; d_b = imm_u; end
            7'b0010111: begin d_ok = 1'b1; d_a = in_pc; d_b = imm_u; end
            default:    d_ok = 1'b0;
        endcase
        if (!d_ok) begin
            d_ctl  = 5'd0;
            d_a    = '0;
            d_b    = '0;
            d_word = 1'b0;
        end
    end

    assign d_ent    = {!d_ok, d_word, d_ok ? in_instr[11:7] : 5'd0, d_ctl, d_a, d_b};
    assign enq      = in_valid && in_ready && (d_ok || PASS_ILLEGAL);
    assign in_ready = !skid_valid;
    assign {out_illegal, out_word, out_rd, out_alu_control, out_operand_a, out_operand_b} = out_q;

    // output register refills from skid first, then from the input; a stalled output diverts into skid
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_q      <= skid_q;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                if (enq) out_q <= d_ent;
                out_valid <= enq;
            end
        end else if (enq) begin
            skid_q     <= d_ent;
            skid_valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed stimulus with a queue scoreboard checked by an independent monitor
module tb_alu_issue_stage;
    typedef struct packed {
        logic        ill;
        logic        word;
        logic [4:0]  rd;
        logic [4:0]  ctl;
        logic [63:0] a;
        logic [63:0] b;
    } ent_t;

    logic        clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0] in_instr = 0;
    logic [63:0] in_pc = 0, in_rs1_data = 0, in_rs2_data = 0;
    logic        in_ready, out_valid, out_word, out_illegal;
    logic [4:0]  out_alu_control, out_rd;
    logic [63:0] out_operand_a, out_operand_b;
    int          checks = 0, failures = 0, cyc = 0;
    ent_t        q[$];

    alu_issue_stage #(.WIDTH(64), .PASS_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu_control(out_alu_control),
        .out_operand_a(out_operand_a), .out_operand_b(out_operand_b), .out_rd(out_rd),
        .out_word(out_word), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ent_t mk(input logic ill, input logic word, input logic [4:0] rd,
                                input logic [4:0] ctl, input logic [63:0] a, input logic [63:0] b);
        mk.ill = ill; mk.word = word; mk.rd = rd; mk.ctl = ctl; mk.a = a; mk.b = b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every completed output handshake must match the oldest expected entry
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            ent_t act, e;
            act = {out_illegal, out_word, out_rd, out_alu_control, out_operand_a, out_operand_b};
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output: got %h expected none", act);
            end else begin
                e = q.pop_front();
                if (act !== e) begin
                    failures++;
                    $display("FAIL issue_entry: got %h expected %h", act, e);
                end
            end
        end
    end

    task automatic send(input logic [31:0] ins, input logic [63:0] pc, input logic [63:0] r1,
                        input logic [63:0] r2, input ent_t exp, output int t);
        int n;
        in_valid = 1; in_instr = ins; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
        end else q.push_back(exp);
        t = cyc;
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain_all();
        int n;
        out_ready = 1;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("drained", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int t1, t2;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_b", out_operand_b, 64'd0);

        @(posedge clk); #1;
        out_ready = 1;
        send(32'h003100B3, 64'h0, 64'd5, 64'd7, mk(0, 0, 1, 5'd0, 64'd5, 64'd7), t1);
        @(negedge clk);
        check("add_latency_valid", 64'(out_valid), 64'd1);
        check("add_ctl", 64'(out_alu_control), 64'd0);
        @(posedge clk); #1;

        send(32'h4030D093, 64'h0, 64'h80, 64'd0, mk(0, 0, 1, 5'd7, 64'h80, 64'd3), t1);
        send(32'hFFF00093, 64'h0, 64'd0, 64'd0, mk(0, 0, 1, 5'd0, 64'd0, 64'hFFFFFFFFFFFFFFFF), t2);
        check("no_gap_accept", 64'(t2 - t1), 64'd1);
        @(negedge clk);
        check("no_gap_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;

        send(32'h12345097, 64'h1000, 64'd9, 64'd9, mk(0, 0, 1, 5'd0, 64'h1000, 64'h12345000), t1);
        send(32'h80000037, 64'h2000, 64'd9, 64'd9, mk(0, 0, 0, 5'd0, 64'd0, 64'hFFFFFFFF80000000), t1);
        send(32'h403100BB, 64'h0, 64'd10, 64'd3, mk(0, 1, 1, 5'd1, 64'd10, 64'd3), t1);
        send(32'h023100B3, 64'h0, 64'd10, 64'd3, mk(1, 0, 0, 5'd0, 64'd0, 64'd0), t1);
        send(32'h0201109B, 64'h0, 64'd10, 64'd3, mk(1, 0, 0, 5'd0, 64'd0, 64'd0), t1);
        send(32'h003130B3, 64'h0, 64'd4, 64'd6, mk(0, 0, 1, 5'd9, 64'd4, 64'd6), t1);
        send(32'h0000007F, 64'h0, 64'd4, 64'd6, mk(1, 0, 0, 5'd0, 64'd0, 64'd0), t1);
        drain_all();

        out_ready = 0;
        send(32'h003140B3, 64'h0, 64'd1, 64'd2, mk(0, 0, 1, 5'd4, 64'd1, 64'd2), t1);
        send(32'h003150B3, 64'h0, 64'd3, 64'd4, mk(0, 0, 1, 5'd6, 64'd3, 64'd4), t1);
        in_valid = 1; in_instr = 32'h003120B3; in_rs1_data = 64'd5; in_rs2_data = 64'd6;
        @(negedge clk);
        check("skid_full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("hold_a", out_operand_a, 64'd1);
        check("hold_ctl", 64'(out_alu_control), 64'd4);
        @(posedge clk); #1;
        out_ready = 1;
        send(32'h003120B3, 64'h0, 64'd5, 64'd6, mk(0, 0, 1, 5'd8, 64'd5, 64'd6), t1);
        drain_all();

        out_ready = 0;
        send(32'h003140B3, 64'h0, 64'd1, 64'd2, mk(0, 0, 1, 5'd4, 64'd1, 64'd2), t1);
        send(32'h003150B3, 64'h0, 64'd3, 64'd4, mk(0, 0, 1, 5'd6, 64'd3, 64'd4), t1);
        in_valid = 1; in_instr = 32'h003100B3; flush = 1;
        @(posedge clk); #1;
        in_valid = 0; flush = 0; q.delete();
        @(negedge clk);
        check("flush_full_out_valid", 64'(out_valid), 64'd0);
        check("flush_full_in_ready", 64'(in_ready), 64'd1);

        send(32'h003140B3, 64'h0, 64'd1, 64'd2, mk(0, 0, 1, 5'd4, 64'd1, 64'd2), t1);
        in_valid = 1; in_instr = 32'h003100B3; flush = 1;
        @(posedge clk); #1;
        in_valid = 0; flush = 0; q.delete();
        @(negedge clk);
        check("flush_accept_out_valid", 64'(out_valid), 64'd0);
        check("flush_accept_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        out_ready = 1;
        repeat (3) @(posedge clk);
        #1 out_ready = 0;

        send(32'h403100BB, 64'h0, 64'd8, 64'd2, mk(0, 1, 1, 5'd1, 64'd8, 64'd2), t1);
        send(32'h4030D093, 64'h0, 64'd8, 64'd2, mk(0, 0, 1, 5'd7, 64'd8, 64'd3), t1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0; q.delete();
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_ctl", 64'(out_alu_control), 64'd0);
        check("rst_a", out_operand_a, 64'd0);
        check("rst_b", out_operand_b, 64'd0);
        check("rst_rd_word_ill", {59'd0, out_rd, out_word, out_illegal} , 64'd0);
        @(posedge clk); #1;
        send(32'h003160B3, 64'h0, 64'd12, 64'd3, mk(0, 0, 1, 5'd3, 64'd12, 64'd3), t1);
        drain_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
